// File: rtl/excp_irq_arb.sv
// Interrupt/exception arbiter: pending capture, lowest-index irq select, trap commit and WFI FSM.
// Optional: define EXCP_IRQ_VECTORED_EN for vectored interrupt targets when mtvec[1:0] = 2'b01.
module excp_irq_arb #(
    parameter int unsigned        NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b0}},
    parameter int unsigned        IRQ_BASE  = 16,
    parameter int unsigned        XLEN      = 32,
    parameter int unsigned        PC_SIZE   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [NUM_IRQ-1:0]  irq_en_i,
    input  logic                status_mie_r,
    input  logic                dbg_mode,
    input  logic                excp_req_i,
    input  logic [XLEN-1:0]     excp_cause_i,
    input  logic                pc_vld_i,
    input  logic [PC_SIZE-1:0]  epc_i,
    input  logic [XLEN-1:0]     csr_mtvec_r,
    input  logic                alu_wfi_i,
    input  logic                wfi_halt_ack,
    output logic                flush_req,
    output logic [PC_SIZE-1:0]  flush_addr,
    output logic                commit_trap,
    output logic [XLEN-1:0]     cmt_cause,
    output logic                cmt_cause_ena,
    output logic [PC_SIZE-1:0]  cmt_epc,
    output logic                cmt_epc_ena,
    output logic [NUM_IRQ-1:0]  irq_pend_o,
    output logic                core_wfi
);

    localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {StIdle, StWfiReq, StWfiSleep} state_e;

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   pend_q, pend_d;
    logic [NUM_IRQ-1:0]   irq_prev_q;
    logic [NUM_IRQ-1:0]   active;
    logic [NUM_IRQ-1:0]   taken_clr;
    logic [IdxW-1:0]      sel_idx;
    logic                 any_active;
    logic                 irq_req;
    logic [XLEN-2:0]      irq_code;
    logic [PC_SIZE-1:0]   tvec_base;

    assign active     = pend_q & irq_en_i;
    assign any_active = |active;
    assign irq_req    = status_mie_r & ~dbg_mode & any_active;

    // Scan downwards so the lowest active index is the last one written.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) sel_idx = IdxW'(i);
        end
    end

    assign irq_code  = (XLEN-1)'(IRQ_BASE) + (XLEN-1)'(sel_idx);
    assign tvec_base = {csr_mtvec_r[PC_SIZE-1:2], 2'b00};

    assign flush_req     = ~rst & (irq_req | excp_req_i);
    // A sleeping core has no committing instruction, so traps wait for wake-up.
    assign commit_trap   = flush_req & pc_vld_i & ~core_wfi;
    assign cmt_cause_ena = commit_trap;
    assign cmt_epc_ena   = commit_trap;
    assign cmt_epc       = epc_i;
    assign cmt_cause     = irq_req ? {1'b1, irq_code} : excp_cause_i;

    always_comb begin
        flush_addr = tvec_base;
        if (!irq_req && dbg_mode) begin
            flush_addr = PC_SIZE'(12'h808);
        end
`ifdef EXCP_IRQ_VECTORED_EN
        else if (irq_req && (csr_mtvec_r[1:0] == 2'b01)) begin
            flush_addr = tvec_base + (PC_SIZE'(irq_code) << 2);
        end
`endif
    end

`ifndef EXCP_IRQ_VECTORED_EN
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_r[1:0];
`endif

    always_comb begin
        taken_clr = '0;
        if (commit_trap && irq_req) taken_clr = NUM_IRQ'(1) << sel_idx;
    end

    // Edge lines hold until taken (a new edge wins over the clear); level lines just follow.
    assign pend_d = (EDGE_MASK & ((irq_i & ~irq_prev_q) | (pend_q & ~taken_clr)))
                  | (~EDGE_MASK & irq_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (alu_wfi_i && pc_vld_i && !flush_req && !dbg_mode) state_d = StWfiReq;
            end
            StWfiReq: begin
                if (any_active || dbg_mode) state_d = StIdle;
                else if (wfi_halt_ack)      state_d = StWfiSleep;
            end
            StWfiSleep: begin
                if (any_active || dbg_mode) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pend_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_i;
        end
    end

    assign irq_pend_o = pend_q;
    assign core_wfi   = (state_q != StIdle);

endmodule

// File: tb/tb_excp_irq_arb.sv
// Scoreboard bench for excp_irq_arb: stimulus pushes expected traps, a negedge monitor checks them.
module tb_excp_irq_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_i, irq_en_i;
    logic        status_mie_r, dbg_mode, excp_req_i, pc_vld_i, alu_wfi_i, wfi_halt_ack;
    logic [31:0] excp_cause_i, epc_i, csr_mtvec_r;
    logic        flush_req, commit_trap, cmt_cause_ena, cmt_epc_ena, core_wfi;
    logic [31:0] flush_addr, cmt_cause, cmt_epc;
    logic [7:0]  irq_pend_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];

`ifdef EXCP_IRQ_VECTORED_EN
    localparam logic [31:0] VecAddr2 = 32'h1048;
`else
    localparam logic [31:0] VecAddr2 = 32'h1000;
`endif

    excp_irq_arb #(
        .NUM_IRQ  (8),
        .EDGE_MASK(8'h22),
        .IRQ_BASE (16),
        .XLEN     (32),
        .PC_SIZE  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irq_i),
        .irq_en_i     (irq_en_i),
        .status_mie_r (status_mie_r),
        .dbg_mode     (dbg_mode),
        .excp_req_i   (excp_req_i),
        .excp_cause_i (excp_cause_i),
        .pc_vld_i     (pc_vld_i),
        .epc_i        (epc_i),
        .csr_mtvec_r  (csr_mtvec_r),
        .alu_wfi_i    (alu_wfi_i),
        .wfi_halt_ack (wfi_halt_ack),
        .flush_req    (flush_req),
        .flush_addr   (flush_addr),
        .commit_trap  (commit_trap),
        .cmt_cause    (cmt_cause),
        .cmt_cause_ena(cmt_cause_ena),
        .cmt_epc      (cmt_epc),
        .cmt_epc_ena  (cmt_epc_ena),
        .irq_pend_o   (irq_pend_o),
        .core_wfi     (core_wfi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] c, input logic [31:0] e, input logic [31:0] a);
        exp_t x;
        x.cause = c;
        x.epc   = e;
        x.addr  = a;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every committed trap must match the oldest expected entry.
    always @(negedge clk) begin
        if (commit_trap === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_trap: got cause %h epc %h expected no trap",
                         cmt_cause, cmt_epc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("trap_cause", cmt_cause, e.cause);
                chk("trap_epc", cmt_epc, e.epc);
                chk("trap_addr", flush_addr, e.addr);
                chk("trap_enas", {30'd0, cmt_cause_ena, cmt_epc_ena}, 32'd3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_i = '0; irq_en_i = '0; status_mie_r = 1'b0; dbg_mode = 1'b0;
        excp_req_i = 1'b1; excp_cause_i = 32'd2; pc_vld_i = 1'b1; epc_i = 32'h100;
        csr_mtvec_r = 32'h1000; alu_wfi_i = 1'b0; wfi_halt_ack = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_flush", flush_req, 0);
        chk("rst_commit", commit_trap, 0);
        chk("rst_enas", {cmt_cause_ena, cmt_epc_ena}, 0);
        step();
        rst = 1'b0; excp_req_i = 1'b0; irq_en_i = 8'hFF; status_mie_r = 1'b1;
        @(negedge clk);
        chk("rst_pend", irq_pend_o, 0);
        chk("rst_wfi", core_wfi, 0);

        // Level line 3: trap one cycle after the line rises.
        step();
        irq_i = 8'h08;
        push(32'h8000_0013, 32'h100, 32'h1000);
        @(negedge clk);
        chk("lvl_lat0", commit_trap, 0);
        step();
        irq_i = 8'h00;
        @(negedge clk);
        chk("lvl_lat1", commit_trap, 1);
        step();
        @(negedge clk);
        chk("lvl_clear", irq_pend_o, 0);

        // Edge lines 1 and 5 pulse together; held pending while no commit slot.
        step();
        pc_vld_i = 1'b0; irq_i = 8'h22; epc_i = 32'h200;
        step();
        irq_i = 8'h00;
        step(); step();
        @(negedge clk);
        chk("edge_hold", irq_pend_o, 8'h22);
        chk("edge_no_commit", commit_trap, 0);
        push(32'h8000_0011, 32'h200, 32'h1000);
        push(32'h8000_0015, 32'h200, 32'h1000);
        step();
        pc_vld_i = 1'b1;
        step();
        @(negedge clk);
        chk("edge_pend5", irq_pend_o, 8'h20);
        step();
        @(negedge clk);
        chk("edge_done", irq_pend_o, 0);

        // Interrupt beats a simultaneous exception, then the exception alone.
        step();
        irq_i = 8'h10;
        step();
        irq_i = 8'h00; excp_req_i = 1'b1; excp_cause_i = 32'd2; epc_i = 32'h300;
        push(32'h8000_0014, 32'h300, 32'h1000);
        step();
        push(32'd2, 32'h300, 32'h1000);
        step();
        excp_req_i = 1'b0;

        // WFI with wake by line 0 while mie = 0: no trap.
        status_mie_r = 1'b0;
        step();
        alu_wfi_i = 1'b1; epc_i = 32'h400;
        step();
        alu_wfi_i = 1'b0;
        @(negedge clk);
        chk("wfi_enter", core_wfi, 1);
        step(); step(); step();
        wfi_halt_ack = 1'b1;
        step();
        wfi_halt_ack = 1'b0;
        @(negedge clk);
        chk("wfi_sleep", core_wfi, 1);
        step();
        irq_i = 8'h01;
        step();
        @(negedge clk);
        chk("wfi_pend", irq_pend_o, 8'h01);
        chk("wfi_still", core_wfi, 1);
        step();
        irq_i = 8'h00;
        @(negedge clk);
        chk("wfi_wake", core_wfi, 0);
        chk("wake_no_flush", flush_req, 0);

        // Reset during WFI.
        step();
        alu_wfi_i = 1'b1;
        step();
        alu_wfi_i = 1'b0;
        @(negedge clk);
        chk("wfi2_enter", core_wfi, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("wfi_rst", core_wfi, 0);
        status_mie_r = 1'b1;

        // Vectored mode requested via mtvec[1:0] = 01.
        csr_mtvec_r = 32'h1001;
        step();
        irq_i = 8'h04;
        step();
        irq_i = 8'h00; epc_i = 32'h500;
        push(32'h8000_0012, 32'h500, VecAddr2);
        step();
        excp_req_i = 1'b1; excp_cause_i = 32'd5;
        push(32'd5, 32'h500, 32'h1000);
        step();
        excp_req_i = 1'b0; csr_mtvec_r = 32'h1000;

        // Debug mode: exceptions go to 0x808, interrupts are masked.
        step();
        dbg_mode = 1'b1; excp_req_i = 1'b1; excp_cause_i = 32'd3; epc_i = 32'h600;
        push(32'd3, 32'h600, 32'h808);
        step();
        excp_req_i = 1'b0; irq_i = 8'h08;
        step();
        irq_i = 8'h00;
        @(negedge clk);
        chk("dbg_pend", irq_pend_o, 8'h08);
        chk("dbg_no_irq", flush_req, 0);
        step();
        dbg_mode = 1'b0;

        step(); step(); step();
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/excp_irq_arb.md
EXCP_IRQ_ARB -- requirements
Module: excp_irq_arb

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt lines (1..32).
REQ-002 Parameter EDGE_MASK, default {NUM_IRQ{1'b0}}, per line: 1 = edge-triggered, 0 = level.
REQ-003 Parameter IRQ_BASE, default 16, cause code of line 0.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 irq_i  in  NUM_IRQ  raw interrupt lines.
REQ-007 irq_en_i  in  NUM_IRQ  per-line enable (mie bits).
REQ-008 status_mie_r  in  1  global interrupt enable.
REQ-009 dbg_mode  in  1  core in debug mode.
REQ-010 excp_req_i  in  1  synchronous exception request from ALU.
REQ-011 excp_cause_i  in  XLEN  exception cause code.
REQ-012 pc_vld_i  in  1  instruction at commit point is valid.
REQ-013 epc_i  in  PC_SIZE  PC of the committing instruction.
REQ-014 csr_mtvec_r  in  XLEN  trap vector CSR.
REQ-015 alu_wfi_i  in  1  committing instruction is WFI.
REQ-016 wfi_halt_ack  in  1  pipeline-halted acknowledge.
REQ-017 flush_req  out  1  trap flush request.
REQ-018 flush_addr  out  PC_SIZE  trap target.
REQ-019 commit_trap  out  1  trap taken this cycle.
REQ-020 cmt_cause / cmt_cause_ena  out  XLEN / 1  mcause write.
REQ-021 cmt_epc / cmt_epc_ena  out  PC_SIZE / 1  mepc write.
REQ-022 irq_pend_o  out  NUM_IRQ  registered pending vector.
REQ-023 core_wfi  out  1  core in WFI state.

Function
REQ-024 Level line: pend[i] is the registered sample of irq_i[i], 1-cycle latency.
REQ-025 Edge line: pend[i] sets on a 0->1 transition of irq_i[i] versus its registered previous sample, and clears only when line i is taken; if set and clear coincide, set wins.
REQ-026 irq_req = status_mie_r & ~dbg_mode & |(pend & irq_en_i), combinational from registered state.
REQ-027 Selected line is the lowest index with pend & irq_en_i set.
REQ-028 flush_req = irq_req | excp_req_i; an interrupt takes priority over a simultaneous exception.
REQ-029 commit_trap = flush_req & pc_vld_i; cmt_cause_ena = cmt_epc_ena = commit_trap.
REQ-030 cmt_cause: interrupt = {1'b1, zero-extended IRQ_BASE+idx}; exception = excp_cause_i.
REQ-031 cmt_epc = epc_i.
REQ-032 flush_addr: exception in dbg_mode = 'h808; otherwise {mtvec[PC_SIZE-1:2], 2'b00}.
REQ-033 FSM states: IDLE, WFI_REQ, WFI_SLEEP.
REQ-034 IDLE -> WFI_REQ when alu_wfi_i & pc_vld_i & ~flush_req & ~dbg_mode.
REQ-035 WFI_REQ -> WFI_SLEEP on wfi_halt_ack.
REQ-036 WFI_REQ or WFI_SLEEP -> IDLE when |(pend & irq_en_i), independent of status_mie_r, or when dbg_mode is high.
REQ-037 core_wfi = 1 in WFI_REQ and WFI_SLEEP.
REQ-038 Wake with status_mie_r = 0 resumes execution without a trap.
REQ-039 No trap is committed while core_wfi = 1.

Reset
REQ-040 On rst: pend, previous samples and irq_pend_o = 0; state = IDLE; core_wfi = 0.
REQ-041 flush_req, commit_trap and the cmt_*_ena outputs are 0 while rst is high.
REQ-042 rst asserted mid-WFI returns the FSM to IDLE on the next edge.

Configuration
REQ-043 With EXCP_IRQ_VECTORED_EN defined and mtvec[1:0] = 2'b01, interrupt flush_addr = base + 4*(IRQ_BASE+idx); exceptions use base.
REQ-044 Without EXCP_IRQ_VECTORED_EN, all non-debug traps go to base regardless of mtvec[1:0].

Verification
REQ-045 Level line 3 high, irq_en_i[3] = 1, mie = 1, pc_vld_i = 1 -> commit_trap one cycle after irq_i rises, cmt_cause = 0x80000013.
REQ-046 Edge lines 1 and 5 pulse together -> line 1 taken first, then line 5; pend[5] stays set until taken.
REQ-047 irq and excp_req_i (cause 2) in the same cycle -> interrupt cause committed, exception not committed.
REQ-048 WFI committed, halt_ack after 3 cycles, line 0 rises with mie = 0 -> core_wfi drops, FSM returns to IDLE, no commit_trap.
REQ-049 With EXCP_IRQ_VECTORED_EN, mtvec = 0x1001, line 2 taken -> flush_addr = 0x1048.
REQ-050 dbg_mode = 1 with excp_req_i -> flush_addr = 0x808; with a pending irq -> no irq_req.
